// File: rtl/pipe_stage_seq.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_seq
// Description : Job sequencer for the reconfigurable pipe-stage datapath.
//               Accepts one job descriptor (mode, beats per stage, stage
//               count), walks the datapath through each stage, paces operand
//               beats against upstream valid / downstream ready, waits for the
//               datapath to flush each stage and pulses done at job end.
// Ports       : CLK_i / RST_i          clock, async active-low reset
//               job_*                  job descriptor valid/ready handshake
//               in_valid_i/in_ready_o  operand beat handshake
//               out_ready_i            downstream backpressure
//               stall_o, stage_o, stage_boundary_o, mode_o  datapath control
//               finished_i             datapath flushed current stage
//               busy_o, done_o, err_o  status
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_seq #(
    parameter int NUM_STAGES = 5,
    parameter int STAGE_W    = 3,
    parameter int LEN_W      = 8,
    parameter int MODE_W     = 2
) (
    input  logic               CLK_i,
    input  logic               RST_i,
    input  logic               job_valid_i,
    output logic               job_ready_o,
    input  logic [MODE_W-1:0]  job_mode_i,
    input  logic [LEN_W-1:0]   job_len_i,
    input  logic [STAGE_W-1:0] job_stages_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               out_ready_i,
    output logic               stall_o,
    output logic [STAGE_W-1:0] stage_o,
    output logic               stage_boundary_o,
    output logic [MODE_W-1:0]  mode_o,
    input  logic               finished_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // One bit wider than the stage index so NUM_STAGES == 2^STAGE_W still fits.
    localparam logic [STAGE_W:0] c_MAX_STAGES = (STAGE_W+1)'(NUM_STAGES);

    logic [1:0]         r_state;
    logic [STAGE_W-1:0] r_stage;
    logic [MODE_W-1:0]  r_mode;
    logic [LEN_W-1:0]   r_cnt;
    // Terminal values are stored pre-decremented (len-1, stages-1) so that
    // the maximum length 2^LEN_W-1 and a full stage count both fit without
    // an extra bit; zero-valued jobs never enter RUN so the wrap is unused.
    logic [LEN_W-1:0]   r_last_beat;
    logic [STAGE_W-1:0] r_last_stage;
    logic               r_err;

    logic               w_run;
    logic               w_fire;
    logic               w_last_beat;
    logic [STAGE_W:0]   w_stages_ext;
    logic [STAGE_W:0]   w_stages_clamp;
    logic [STAGE_W-1:0] w_last_stage_in;
    logic               w_zero_job;

    always_comb begin
        w_run           = (r_state == c_RUN);
        w_fire          = w_run & in_valid_i & out_ready_i;
        w_last_beat     = (r_cnt == r_last_beat);
        w_stages_ext    = {1'b0, job_stages_i};
        w_stages_clamp  = (w_stages_ext > c_MAX_STAGES) ? c_MAX_STAGES : w_stages_ext;
        w_last_stage_in = STAGE_W'(w_stages_clamp - (STAGE_W+1)'(1));
        w_zero_job      = (job_len_i == '0) || (job_stages_i == '0);
    end

    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            r_state      <= c_IDLE;
            r_stage      <= '0;
            r_mode       <= '0;
            r_cnt        <= '0;
            r_last_beat  <= '0;
            r_last_stage <= '0;
            r_err        <= 1'b0;
        end else begin
            // A flush indication outside DRAIN is a protocol violation; it is
            // recorded but otherwise ignored.
            if (finished_i && (r_state != c_DRAIN)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (job_valid_i) begin
                        r_mode       <= job_mode_i;
                        r_stage      <= '0;
                        r_cnt        <= '0;
                        r_last_beat  <= job_len_i - LEN_W'(1);
                        r_last_stage <= w_last_stage_in;
                        r_state      <= w_zero_job ? c_DONE : c_RUN;
                    end
                end
                c_RUN: begin
                    if (w_fire) begin
                        if (w_last_beat) begin
                            r_cnt   <= '0;
                            r_state <= c_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                c_DRAIN: begin
                    if (finished_i) begin
                        if (r_stage == r_last_stage) begin
                            r_state <= c_DONE;
                        end else begin
                            r_stage <= r_stage + STAGE_W'(1);
                            r_state <= c_RUN;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        job_ready_o      = (r_state == c_IDLE);
        in_ready_o       = w_run & out_ready_i;
        stall_o          = ~w_fire;
        stage_boundary_o = w_fire & w_last_beat;
        busy_o           = w_run | (r_state == c_DRAIN);
        done_o           = (r_state == c_DONE);
        err_o            = r_err;
        stage_o          = r_stage;
        mode_o           = r_mode;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_seq.md
Name: pipe_stage_seq

Overview:
- Job sequencer for the reconfigurable pipe-stage datapath.
- Accepts one job descriptor (tile mode, beats per stage, number of stages) over a valid/ready handshake.
- Steps the datapath through its stages by driving stage index, mode, stall and stage-boundary.
- Paces operand beats against upstream validity and downstream backpressure, waits for the datapath's per-stage finished indication, and signals job completion.

Parameters:
- NUM_STAGES, 5: maximum stages per job.
- STAGE_W, 3: width of the stage index; must satisfy 2^STAGE_W >= NUM_STAGES.
- LEN_W, 8: width of the beats-per-stage count.
- MODE_W, 2: width of the tile mode field.

Ports:
- CLK_i  in  1  single clock, rising edge.
- RST_i  in  1  reset, asynchronous, active-low.
- job_valid_i  in  1  job descriptor valid.
- job_ready_o  out  1  sequencer can accept a job.
- job_mode_i  in  MODE_W  tile mode for the job.
- job_len_i  in  LEN_W  operand beats per stage.
- job_stages_i  in  STAGE_W  stages to run.
- in_valid_i  in  1  operand beat available upstream.
- in_ready_o  out  1  operand beat consumed this cycle when in_valid_i is also high.
- out_ready_i  in  1  downstream can accept datapath output.
- stall_o  out  1  freezes the datapath.
- stage_o  out  STAGE_W  current stage index.
- stage_boundary_o  out  1  last beat of the current stage.
- mode_o  out  MODE_W  reconfigurable-tile mode.
- finished_i  in  1  datapath has flushed the current stage.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle job-complete pulse.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset values (while RST_i low, async):
  - state = IDLE; stage_o = 0; mode_o = 0; beat counter = 0.
  - stall_o = 1; job_ready_o = 1; in_ready_o = 0.
  - stage_boundary_o = 0; busy_o = 0; done_o = 0; err_o = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - job_ready_o = 1.
  - On job_valid_i & job_ready_o: latch mode, len and stages. Stages greater than NUM_STAGES are clamped to NUM_STAGES.
  - Also on accept: mode_o <= job_mode_i, stage_o <= 0, beat counter <= 0.
  - Next state is DONE if len==0 or stages==0; otherwise RUN.
- RUN:
  - fire = in_valid_i & out_ready_i.
  - in_ready_o = out_ready_i; stall_o = ~fire; job_ready_o = 0.
  - Each fire increments the beat counter.
  - stage_boundary_o = fire & (counter == len-1). This is combinational, in the same cycle as the last beat.
  - On that beat: counter <= 0, next state DRAIN.
- DRAIN:
  - stall_o = 1; in_ready_o = 0.
  - On finished_i: if stage_o == stages-1, go to DONE. Otherwise stage_o <= stage_o+1 and return to RUN.
  - No timeout; DRAIN persists until finished_i or reset.
- DONE:
  - done_o = 1 for exactly one cycle, then IDLE.
  - stage_o and mode_o hold their last values until the next job is accepted.
- busy_o = 1 in RUN and DRAIN.
- finished_i is sampled only in DRAIN. finished_i high in any other state sets err_o, which stays set until reset. Sequencing is not otherwise affected.
- job_valid_i outside IDLE is ignored; job_ready_o = 0 holds the requester.
- Reset asserted mid-job (any state) returns immediately to IDLE with reset values. No done_o is issued for the aborted job.
- Counter widths: beat counter is LEN_W bits; len = 2^LEN_W-1 must complete without wrap. stage_o never exceeds NUM_STAGES-1.
- Latency:
  - Accept to first possible beat: 1 cycle.
  - finished_i of the last stage to done_o: 1 cycle.
  - finished_i of an intermediate stage to the next beat: 1 cycle.

Test Plan:
- Reset: hold RST_i low, then release → all outputs at the reset values listed above; job_ready_o = 1, stall_o = 1.
- Nominal run:
  - Stimulus: job mode=2, len=4, stages=2; in_valid_i = out_ready_i = 1; finished_i pulsed 3 cycles after each boundary.
  - Required response: mode_o = 2; stage_o = 0 for 4 beats with boundary on beat 4; stall_o = 1 for the 3 DRAIN cycles; stage_o = 1 for 4 beats, then boundary; done_o pulses 1 cycle after the second finished_i; busy_o falls with it.
- Backpressure:
  - Stimulus: out_ready_i low for 2 cycles after beat 2 of len=4.
  - Required response: stall_o = 1 and in_ready_o = 0 for those 2 cycles; beat count holds; boundary still lands on the 4th fired beat.
- Zero-length job: len=0, stages=3 → DONE the cycle after accept; done_o pulses once; no boundary; stage_o = 0.
- Clamp: stages=7 with NUM_STAGES=5, len=1 → exactly 5 boundaries, stage_o sequence 0..4, then done_o.
- Protocol error and abort:
  - finished_i pulsed during RUN → err_o = 1 and stays 1; the job still completes normally.
  - RST_i dropped during DRAIN → IDLE at once; no done_o; err_o cleared.
